// File: rtl/fwd_history_buffer.sv
// Operand-forwarding history buffer: tracks the last DEPTH register writes (including
// pending loads) and serves NRD read channels with the youngest in-flight value.
module fwd_history_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int NRD    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push_en,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      push_ready,
  input  logic                      fill_en,
  input  logic [ADDR_W-1:0]         fill_addr,
  input  logic [DATA_W-1:0]         fill_data,
  input  logic [NRD*ADDR_W-1:0]     rd_addr,
  input  logic [NRD*DATA_W-1:0]     rf_data,
  output logic [NRD*DATA_W-1:0]     src,
  output logic [NRD-1:0]            hit,
  output logic [NRD-1:0]            stall,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NRD*DATA_W-1:0] src_q, src_d;
  logic [NRD-1:0]        hit_q, hit_d;
  logic [NRD-1:0]        stall_q, stall_d;

  logic [PTR_W-1:0]  fill_idx;
  logic              fill_done;
  logic [PTR_W-1:0]  rd_idx;
  logic              rd_found;
  logic [ADDR_W-1:0] rd_a;

  // Next-state contents: fill on existing entries first, then the push, flush overrides both.
  // head_q always points at the next slot to write, which is the oldest entry once full.
  always_comb begin
    valid_d   = valid_q;
    ready_d   = ready_q;
    addr_d    = addr_q;
    data_d    = data_q;
    head_d    = head_q;
    count_d   = count_q;
    fill_done = 1'b0;
    fill_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_idx = head_q - PTR_W'(i + 1);
      if (fill_en && !fill_done && valid_q[fill_idx] && !ready_q[fill_idx] &&
          addr_q[fill_idx] == fill_addr) begin
        fill_done          = 1'b1;
        data_d[fill_idx]   = fill_data;
        ready_d[fill_idx]  = 1'b1;
      end
    end
    if (push_en && push_addr != '0) begin
      valid_d[head_q] = 1'b1;
      ready_d[head_q] = push_ready;
      addr_d[head_q]  = push_addr;
      data_d[head_q]  = push_data;
      head_d          = head_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
    end
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      count_d = '0;
    end
  end

  // Lookups see the effective (next-state) contents, scanned youngest-first.
  always_comb begin
    src_d    = rf_data;
    hit_d    = '0;
    stall_d  = '0;
    rd_found = 1'b0;
    rd_idx   = '0;
    rd_a     = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_a     = rd_addr[k*ADDR_W +: ADDR_W];
      rd_found = 1'b0;
      if (rd_a == '0) begin
        src_d[k*DATA_W +: DATA_W] = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          rd_idx = head_d - PTR_W'(i + 1);
          if (!rd_found && valid_d[rd_idx] && addr_d[rd_idx] == rd_a) begin
            rd_found = 1'b1;
            hit_d[k] = 1'b1;
            if (ready_d[rd_idx]) begin
              src_d[k*DATA_W +: DATA_W] = data_d[rd_idx];
            end else begin
              src_d[k*DATA_W +: DATA_W] = '1;
              stall_d[k]                = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      count_q <= '0;
      src_q   <= '0;
      hit_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      count_q <= count_d;
      src_q   <= src_d;
      hit_q   <= hit_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

  assign src   = src_q;
  assign hit   = hit_q;
  assign stall = stall_q;
  assign count = count_q;

endmodule

// File: tb/tb_fwd_history_buffer.sv
// Self-checking bench for fwd_history_buffer: directed test-plan sequences followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fwd_history_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int NRD    = 2;

  logic                  clk = 1'b0;
  logic                  rst, flush, push_en, push_ready, fill_en;
  logic [ADDR_W-1:0]     push_addr, fill_addr;
  logic [DATA_W-1:0]     push_data, fill_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rf_data;
  logic [NRD*DATA_W-1:0] src;
  logic [NRD-1:0]        hit, stall;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  fwd_history_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en(push_en), .push_addr(push_addr), .push_data(push_data), .push_ready(push_ready),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .rd_addr(rd_addr), .rf_data(rf_data),
    .src(src), .hit(hit), .stall(stall), .count(count)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;
  } entry_t;

  // Reference history: oldest at the front, youngest at the back.
  entry_t hist[$];
  logic [DATA_W-1:0] expSrc [NRD];
  logic              expHit [NRD];
  logic              expStall [NRD];
  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic modelStep();
    logic [ADDR_W-1:0] a;
    entry_t e;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < NRD; k++) begin
        expSrc[k] = '0; expHit[k] = 1'b0; expStall[k] = 1'b0;
      end
      return;
    end
    if (flush) begin
      hist.delete();
    end else begin
      if (fill_en) begin
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i].addr == fill_addr && !hist[i].ready) begin
            hist[i].data  = fill_data;
            hist[i].ready = 1'b1;
            break;
          end
        end
      end
      if (push_en && push_addr != 0) begin
        if (hist.size() == DEPTH) void'(hist.pop_front());
        e.addr = push_addr; e.data = push_data; e.ready = push_ready;
        hist.push_back(e);
      end
    end
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      expSrc[k] = rf_data[k*DATA_W +: DATA_W]; expHit[k] = 1'b0; expStall[k] = 1'b0;
      if (a == 0) begin
        expSrc[k] = '0;
      end else begin
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i].addr == a) begin
            expHit[k] = 1'b1;
            if (hist[i].ready) expSrc[k] = hist[i].data;
            else begin expSrc[k] = '1; expStall[k] = 1'b1; end
            break;
          end
        end
      end
    end
  endtask

  // One clock: inputs already set, model advances at the edge, outputs checked just after.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    for (int k = 0; k < NRD; k++) begin
      checkOutput($sformatf("src%0d", k), src[k*DATA_W +: DATA_W], expSrc[k]);
      checkOutput($sformatf("hit%0d", k), 32'(hit[k]), 32'(expHit[k]));
      checkOutput($sformatf("stall%0d", k), 32'(stall[k]), 32'(expStall[k]));
    end
    checkOutput("count", 32'(count), 32'(hist.size()));
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; push_en = 1'b0; push_addr = '0; push_data = '0; push_ready = 1'b0;
    fill_en = 1'b0; fill_addr = '0; fill_data = '0; rd_addr = '0; rf_data = '0;
  endtask

  task automatic setPush(input int a, input logic [DATA_W-1:0] d, input logic rdy);
    push_en = 1'b1; push_addr = ADDR_W'(a); push_data = d; push_ready = rdy;
  endtask

  task automatic setRd(input int a0, input int a1, input logic [DATA_W-1:0] r0, input logic [DATA_W-1:0] r1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    rf_data = {r1, r0};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    applyStimulus();
    checkOutput("reset_src", src[31:0], 32'h0);
    checkOutput("reset_count", 32'(count), 32'd0);

    idle(); setPush(8, 32'h0000_1234, 1'b1); applyStimulus();
    idle(); setRd(8, 9, 32'hAAAA_AAAA, 32'hAAAA_AAAA); applyStimulus();
    checkOutput("tp1_src0", src[31:0], 32'h0000_1234);
    checkOutput("tp1_src1", src[63:32], 32'hAAAA_AAAA);

    idle(); setPush(5, 32'h0, 1'b0); setRd(5, 0, 32'h1, 32'h2); applyStimulus();
    checkOutput("tp2_stall", 32'(stall[0]), 32'd1);
    checkOutput("tp2_src", src[31:0], 32'hFFFF_FFFF);
    idle(); fill_en = 1'b1; fill_addr = 5'd5; fill_data = 32'hDEAD_BEEF; setRd(5, 0, 32'h1, 32'h2); applyStimulus();
    checkOutput("tp2_fill", src[31:0], 32'hDEAD_BEEF);

    idle(); setPush(3, 32'd1, 1'b1); applyStimulus();
    idle(); setPush(3, 32'd2, 1'b1); applyStimulus();
    idle(); setPush(3, 32'd0, 1'b0); setRd(3, 3, 32'h7, 32'h7); applyStimulus();
    checkOutput("tp3_stall", 32'(stall[1]), 32'd1);

    idle(); flush = 1'b1; applyStimulus();
    for (int w = 0; w < 3; w++) begin
      for (int v = 1; v <= 5; v++) begin
        idle(); setPush(v, DATA_W'(v), 1'b1); applyStimulus();
      end
      idle(); setRd(1, 5, 32'hBBBB_BBBB, 32'hCCCC_CCCC); applyStimulus();
      checkOutput("tp4_miss", src[31:0], 32'hBBBB_BBBB);
      checkOutput("tp4_hit", src[63:32], 32'd5);
      checkOutput("tp4_count", 32'(count), 32'd4);
    end

    idle(); setPush(0, 32'h55, 1'b1); setRd(0, 0, 32'h77, 32'h77); applyStimulus();
    checkOutput("tp5_r0src", src[31:0], 32'h0);
    checkOutput("tp5_r0count", 32'(count), 32'd4);
    idle(); flush = 1'b1; setPush(7, 32'h70, 1'b1); setRd(7, 7, 32'h11, 32'h22); applyStimulus();
    checkOutput("tp5_flushcount", 32'(count), 32'd0);

    idle(); setPush(6, 32'h0, 1'b0); applyStimulus();
    idle(); rst = 1'b1; setRd(6, 6, 32'h5, 32'h5); applyStimulus();
    checkOutput("tp6_rsthit", 32'(hit), 32'd0);
    idle(); fill_en = 1'b1; fill_addr = 5'd6; fill_data = 32'h1234_5678; setRd(6, 6, 32'h99, 32'h99); applyStimulus();
    checkOutput("tp6_fillignored", src[31:0], 32'h99);

    for (int n = 0; n < 500; n++) begin
      idle();
      rst        = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      push_en    = ($urandom_range(0, 2) != 0);
      push_addr  = ADDR_W'($urandom_range(0, 7));
      push_data  = $urandom;
      push_ready = ($urandom_range(0, 2) != 0);
      fill_en    = ($urandom_range(0, 2) == 0);
      fill_addr  = ADDR_W'($urandom_range(0, 7));
      fill_data  = $urandom;
      setRd($urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_history_buffer.md
# fwd_history_buffer

Parametrised operand-forwarding unit for the multi-cycle MIPS datapath, succeeding the fixed 3-source forwarding mux. It keeps a circular history of the last DEPTH register writes, including writes whose data is still pending, such as loads. For each of NRD read channels it returns the youngest matching in-flight value or the register-file value, flags a stall when the youngest match is not yet ready, and registers all results.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- DEPTH, 4, history entries (power of two, ≥2)
- NRD, 2, read channels
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  invalidate all entries
- push_en  in  1  allocate a new youngest entry
- push_addr  in  ADDR_W  destination register of the pushed entry
- push_data  in  DATA_W  data for the pushed entry
- push_ready  in  1  push_data is valid now (0 = pending, e.g. load)
- fill_en  in  1  complete a pending entry
- fill_addr  in  ADDR_W  register being completed
- fill_data  in  DATA_W  completed data
- rd_addr  in  NRD*ADDR_W  lookup addresses; channel k = bits [k*ADDR_W +: ADDR_W]
- rf_data  in  NRD*DATA_W  register-file read data per channel
- src  out  NRD*DATA_W  forwarded operand per channel (registered)
- hit  out  NRD  channel was served from the buffer (registered)
- stall  out  NRD  youngest match is pending (registered)
- count  out  clog2(DEPTH)+1  number of valid entries

## Operation
- Each entry holds valid, addr, data, and ready. Entries are ordered by age in a circular buffer with a head pointer. Age order must be preserved across wrap-around.
- Push: writes {1, push_addr, push_data, push_ready} as the youngest entry.
  - If count==DEPTH, the oldest entry is overwritten and count stays at DEPTH. The datapath guarantees that the overwritten value is already in the register file.
  - A push with push_addr==0 is ignored (no entry, count unchanged).
- Fill: updates data and sets ready=1 on the youngest valid entry with addr==fill_addr and ready==0. If no such entry exists, the fill is ignored. Fill only acts on entries present before this edge.
- Flush: all entries become invalid and count becomes 0. Flush beats a same-cycle push or fill; both are discarded.
- Lookup per channel k uses the effective contents: the current entries, then this cycle's fill applied, then this cycle's push added as the youngest entry. Flush makes the effective contents empty.
  - rd_addr==0: src=0, hit=0, stall=0.
  - The youngest valid match is ready: src=entry data, hit=1, stall=0.
  - The youngest valid match is pending: src=32'hFFFFFFFF (all ones at DATA_W), hit=1, stall=1. Older ready matches of the same address must not be used.
  - No match: src=rf_data[k], hit=0, stall=0.
- Channels are independent. Any number of channels may match the same entry.

## Timing
- Reset values: all entries invalid, head=0, count=0, src=0, hit=0, stall=0.
- Lookup latency is 1 cycle. src, hit, and stall reflect rd_addr/rf_data sampled at edge N and are valid after edge N.
- Lookup is evaluated every cycle; there is no request handshake.
- Push and fill become visible to a lookup sampled at the same edge, per the effective-contents rule above.
- count updates at the same edge as push or flush.
- Asserting rst mid-operation discards all entries and pending fills. The first edge with rst high forces all outputs to their reset values.
- Implementation constraint: DEPTH-way comparison per channel with a youngest-first priority select. There is no multicycle path.

## Test plan
- Reset, then push r8=0x0000_1234 (ready); next cycle look up r8 on ch0 and r9 on ch1 with rf_data=0xAAAA_AAAA → ch0 src=0x0000_1234, hit=1; ch1 src=0xAAAA_AAAA, hit=0.
- Push r5 pending; the same cycle look up r5 → stall=1, src=0xFFFF_FFFF. Next cycle fill r5=0xDEAD_BEEF while looking up r5 → src=0xDEAD_BEEF, stall=0.
- Push r3=1, then r3=2 (ready), then r3 pending; look up r3 → stall=1, because the older ready copies are ignored.
- With DEPTH=4, push r1..r5 (values 1..5) → count=4; look up r1 returns rf_data (hit=0), r5 returns 5. Repeat for 3 wraps with identical results.
- Push r0=0x55 and look up r0 with rf_data=0x77 → src=0, hit=0, count unchanged. Flush together with a push of r7 → count=0 and a lookup of r7 misses.
- Assert rst for one cycle while a pending entry exists → all outputs 0, count=0. A fill on the next cycle is ignored.
